// File: rtl/cell_plotter_if.sv
// Command and pixel-stream bundle between the board controller and the cell plotter.
// The master modport is the board side and the slave modport is the plotter side.
interface cell_plotter_if;
    logic       draw_cell;
    logic       plot_empty;
    logic       place_disk;
`ifdef CELL_PLOTTER_CLEAR_EN
    logic       clear_board;
`endif
    logic [2:0] cell_x;
    logic [2:0] cell_y;
    logic       side;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
`ifdef CELL_PLOTTER_CLEAR_EN
        output clear_board,
`endif
        output draw_cell, plot_empty, place_disk, cell_x, cell_y, side,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
`ifdef CELL_PLOTTER_CLEAR_EN
        input  clear_board,
`endif
        input  draw_cell, plot_empty, place_disk, cell_x, cell_y, side,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/cell_plotter.sv
// Rasterises one board cell per command into single-pixel writes for a 160x120 3-bit frame.
// Defining CELL_PLOTTER_CLEAR_EN adds clear_board, which sweeps all 64 cells as empty cells.
module cell_plotter #(
    parameter int CELL_PX  = 14,
    parameter int BOARD_X0 = 24,
    parameter int BOARD_Y0 = 4
) (
    input  logic            clk,
    input  logic            restart,
    cell_plotter_if.slave   bus
);

    if (CELL_PX < 4 || CELL_PX > 15 ||
        BOARD_X0 + 8 * CELL_PX > 160 || BOARD_Y0 + 8 * CELL_PX > 120) begin : g_bad_params
        $error("cell_plotter: board geometry does not fit the 160x120 frame");
    end

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;
    typedef enum logic [1:0] {M_EMPTY, M_CURSOR, M_DISK, M_CLEAR} mode_t;

    localparam logic [3:0] PX_LAST = 4'(CELL_PX - 1);
    localparam logic [5:0] DIAM    = 6'(CELL_PX - 1);
    localparam logic [9:0] R_SQ    = 10'((CELL_PX - 3) * (CELL_PX - 3));

    state_t     state_reg;
    mode_t      mode_reg;
    logic [2:0] cx_reg;
    logic [2:0] cy_reg;
    logic       side_reg;
    logic [3:0] px_reg;
    logic [3:0] py_reg;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [2:0] colour_reg;
    logic       plot_reg;
    logic       busy_reg;
    logic       done_reg;
`ifdef CELL_PLOTTER_CLEAR_EN
    logic [5:0] cell_idx_reg;
`endif

    // Command decode: place_disk > draw_cell > plot_empty (clear_board above all).
    logic  cmd_any;
    mode_t cmd_mode;
    always_comb begin
        cmd_any  = bus.place_disk | bus.draw_cell | bus.plot_empty;
        cmd_mode = M_EMPTY;
        if (bus.place_disk)
            cmd_mode = M_DISK;
        else if (bus.draw_cell)
            cmd_mode = M_CURSOR;
`ifdef CELL_PLOTTER_CLEAR_EN
        if (bus.clear_board) begin
            cmd_any  = 1'b1;
            cmd_mode = M_CLEAR;
        end
`endif
    end

    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic       last_cell;
    always_comb begin
        cur_x     = cx_reg;
        cur_y     = cy_reg;
        last_cell = 1'b1;
`ifdef CELL_PLOTTER_CLEAR_EN
        if (mode_reg == M_CLEAR) begin
            cur_x     = cell_idx_reg[2:0];
            cur_y     = cell_idx_reg[5:3];
            last_cell = (cell_idx_reg == 6'd63);
        end
`endif
    end

    // Modular 8/7-bit sums give the same bits as truncating the 9-bit sums.
    logic [7:0] x_pix;
    logic [6:0] y_pix;
    always_comb begin
        x_pix = 8'(BOARD_X0) + 8'(cur_x) * 8'(CELL_PX) + 8'(px_reg);
        y_pix = 7'(BOARD_Y0) + 7'(cur_y) * 7'(CELL_PX) + 7'(py_reg);
    end

    // Disk test in doubled coordinates keeps the centre on an integer grid.
    logic signed [9:0] dx;
    logic signed [9:0] dy;
    logic        [9:0] dist_sq;
    logic              in_disk;
    logic              border;
    logic        [2:0] pix_colour;
    always_comb begin
        dx      = $signed({5'd0, px_reg, 1'b0}) - $signed({4'd0, DIAM});
        dy      = $signed({5'd0, py_reg, 1'b0}) - $signed({4'd0, DIAM});
        dist_sq = 10'(dx * dx) + 10'(dy * dy);
        in_disk = (dist_sq <= R_SQ);
        border  = (px_reg == 4'd0) || (py_reg == 4'd0);
        if (border)
            pix_colour = (mode_reg == M_CURSOR) ? 3'b110 : 3'b000;
        else if (mode_reg == M_DISK && in_disk)
            pix_colour = side_reg ? 3'b111 : 3'b000;
        else
            pix_colour = 3'b010;
    end

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            state_reg    <= S_IDLE;
            mode_reg     <= M_EMPTY;
            cx_reg       <= 3'd0;
            cy_reg       <= 3'd0;
            side_reg     <= 1'b0;
            px_reg       <= 4'd0;
            py_reg       <= 4'd0;
            x_reg        <= 8'd0;
            y_reg        <= 7'd0;
            colour_reg   <= 3'd0;
            plot_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef CELL_PLOTTER_CLEAR_EN
            cell_idx_reg <= 6'd0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    plot_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (cmd_any) begin
                        mode_reg     <= cmd_mode;
                        cx_reg       <= bus.cell_x;
                        cy_reg       <= bus.cell_y;
                        side_reg     <= bus.side;
                        px_reg       <= 4'd0;
                        py_reg       <= 4'd0;
`ifdef CELL_PLOTTER_CLEAR_EN
                        cell_idx_reg <= 6'd0;
`endif
                        state_reg    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    plot_reg   <= 1'b1;
                    busy_reg   <= 1'b1;
                    x_reg      <= x_pix;
                    y_reg      <= y_pix;
                    colour_reg <= pix_colour;
                    if (px_reg == PX_LAST) begin
                        px_reg <= 4'd0;
                        if (py_reg == PX_LAST) begin
                            py_reg <= 4'd0;
                            if (last_cell)
                                state_reg <= S_FIN;
`ifdef CELL_PLOTTER_CLEAR_EN
                            else
                                cell_idx_reg <= cell_idx_reg + 6'd1;
`endif
                        end else begin
                            py_reg <= py_reg + 4'd1;
                        end
                    end else begin
                        px_reg <= px_reg + 4'd1;
                    end
                end
                S_FIN: begin
                    plot_reg  <= 1'b0;
                    busy_reg  <= 1'b1;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.x      = x_reg;
    assign bus.y      = y_reg;
    assign bus.colour = colour_reg;
    assign bus.plot   = plot_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter: logs each cycle after a command and checks hand-computed pixels.
module tb_cell_plotter;
    logic clk = 1'b0;
    logic restart;
    always #5 clk = ~clk;

    cell_plotter_if bus ();

    cell_plotter #(.CELL_PX(14), .BOARD_X0(24), .BOARD_Y0(4)) dut (
        .clk     (clk),
        .restart (restart),
        .bus     (bus)
    );

    localparam int LOG_N = 12600;
    int log_x    [LOG_N+1];
    int log_y    [LOG_N+1];
    int log_c    [LOG_N+1];
    int log_plot [LOG_N+1];
    int log_busy [LOG_N+1];
    int log_done [LOG_N+1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Logs n cycles; at cycle inj a stray draw_cell with a new cell_x is injected.
    task automatic observe(input int n, input int inj);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            log_x[i]    = int'(bus.x);
            log_y[i]    = int'(bus.y);
            log_c[i]    = int'(bus.colour);
            log_plot[i] = int'(bus.plot);
            log_busy[i] = int'(bus.busy);
            log_done[i] = int'(bus.done);
            if (i == inj) begin
                bus.draw_cell = 1'b1;
                bus.cell_x    = 3'd5;
            end else if (i == inj + 1) begin
                bus.draw_cell = 1'b0;
            end
        end
    endtask

    function automatic int count_sel(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: c += log_plot[i];
                1: c += log_busy[i];
                default: c += log_done[i];
            endcase
        end
        return c;
    endfunction

    task automatic pulse(input bit pe, input bit dc, input bit pd,
                         input int cx, input int cy, input bit sd);
        @(negedge clk);
        bus.plot_empty = pe;
        bus.draw_cell  = dc;
        bus.place_disk = pd;
        bus.cell_x     = 3'(cx);
        bus.cell_y     = 3'(cy);
        bus.side       = sd;
        @(negedge clk);
        bus.plot_empty = 1'b0;
        bus.draw_cell  = 1'b0;
        bus.place_disk = 1'b0;
    endtask

    initial begin
        restart        = 1'b1;
        bus.plot_empty = 1'b0;
        bus.draw_cell  = 1'b0;
        bus.place_disk = 1'b0;
        bus.cell_x     = 3'd0;
        bus.cell_y     = 3'd0;
        bus.side       = 1'b0;
`ifdef CELL_PLOTTER_CLEAR_EN
        bus.clear_board = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_plot",   int'(bus.plot),   0);
        chk("reset_busy",   int'(bus.busy),   0);
        chk("reset_done",   int'(bus.done),   0);
        chk("reset_x",      int'(bus.x),      0);
        chk("reset_y",      int'(bus.y),      0);
        chk("reset_colour", int'(bus.colour), 0);
        restart = 1'b0;

        // plot_empty at (0,0)
        pulse(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        observe(200, 0);
        $display("txn plot_empty (0,0): first x=%0d y=%0d c=%0d", log_x[1], log_y[1], log_c[1]);
        chk("empty_plot_cycles",  count_sel(0, 1, 196), 196);
        chk("empty_plot_after",   log_plot[197], 0);
        chk("empty_first_x",      log_x[1], 24);
        chk("empty_first_y",      log_y[1], 4);
        chk("empty_first_colour", log_c[1], 0);
        chk("empty_border_colour", log_c[6], 0);
        chk("empty_interior_1_1", log_c[16], 2);
        chk("empty_last_x",       log_x[196], 37);
        chk("empty_last_y",       log_y[196], 17);
        chk("empty_done_last",    log_done[196], 0);
        chk("empty_done_after",   log_done[197], 1);
        chk("empty_done_count",   count_sel(2, 1, 200), 1);
        chk("empty_busy_draw",    count_sel(1, 1, 196), 196);
        chk("empty_busy_at_done", log_busy[197], 1);
        chk("empty_busy_after",   log_busy[198], 0);

        // draw_cell at (7,7)
        pulse(1'b0, 1'b1, 1'b0, 7, 7, 1'b0);
        observe(200, 0);
        $display("txn draw_cell (7,7): first x=%0d y=%0d c=%0d", log_x[1], log_y[1], log_c[1]);
        chk("cursor_first_x",      log_x[1], 122);
        chk("cursor_first_y",      log_y[1], 102);
        chk("cursor_first_colour", log_c[1], 6);
        chk("cursor_left_border",  log_c[15], 6);
        chk("cursor_interior",     log_c[16], 2);
        chk("cursor_last_x",       log_x[196], 135);
        chk("cursor_last_y",       log_y[196], 115);
        chk("cursor_busy_draw",    count_sel(1, 1, 196), 196);
        chk("cursor_plot_cycles",  count_sel(0, 1, 200), 196);

        // place_disk white at (3,2)
        pulse(1'b0, 1'b0, 1'b1, 3, 2, 1'b1);
        observe(200, 0);
        $display("txn place_disk white (3,2): centre x=%0d y=%0d c=%0d", log_x[106], log_y[106], log_c[106]);
        chk("disk_w_centre_x",      log_x[106], 73);
        chk("disk_w_centre_y",      log_y[106], 39);
        chk("disk_w_centre_colour", log_c[106], 7);
        chk("disk_w_corner_1_1",    log_c[16], 2);
        chk("disk_w_border_top",    log_c[8], 0);
        chk("disk_w_border_left",   log_c[99], 0);

        // place_disk black at (3,2)
        pulse(1'b0, 1'b0, 1'b1, 3, 2, 1'b0);
        observe(200, 0);
        $display("txn place_disk black (3,2): centre c=%0d", log_c[106]);
        chk("disk_b_centre_colour", log_c[106], 0);
        chk("disk_b_interior_1_1",  log_c[16], 2);

        // all three commands together at (1,0); stray draw_cell mid-draw
        pulse(1'b1, 1'b1, 1'b1, 1, 0, 1'b1);
        observe(400, 50);
        $display("txn simultaneous (1,0): centre c=%0d last x=%0d", log_c[106], log_x[196]);
        chk("prio_disk_centre",   log_c[106], 7);
        chk("prio_first_colour",  log_c[1], 0);
        chk("prio_last_x",        log_x[196], 51);
        chk("prio_last_y",        log_y[196], 17);
        chk("prio_plot_total",    count_sel(0, 1, 400), 196);
        chk("prio_done_total",    count_sel(2, 1, 400), 1);

        // restart at pixel 50 of a plot_empty at (2,1)
        pulse(1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
        observe(50, 0);
        chk("abort_plot_before", log_plot[50], 1);
        #1 restart = 1'b1;
        #1;
        $display("txn restart mid-draw: plot=%0d busy=%0d done=%0d", bus.plot, bus.busy, bus.done);
        chk("abort_plot", int'(bus.plot), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        @(negedge clk);
        restart = 1'b0;
        observe(200, 0);
        chk("abort_no_plot", count_sel(0, 1, 200), 0);
        chk("abort_no_done", count_sel(2, 1, 200), 0);

        pulse(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        observe(200, 0);
        $display("txn plot_empty after restart: first x=%0d y=%0d", log_x[1], log_y[1]);
        chk("fresh_first_x",     log_x[1], 24);
        chk("fresh_first_y",     log_y[1], 4);
        chk("fresh_second_x",    log_x[2], 25);
        chk("fresh_plot_cycles", count_sel(0, 1, 200), 196);

`ifdef CELL_PLOTTER_CLEAR_EN
        @(negedge clk);
        bus.clear_board = 1'b1;
        @(negedge clk);
        bus.clear_board = 1'b0;
        observe(12600, 0);
        $display("txn clear_board: last x=%0d y=%0d", log_x[12544], log_y[12544]);
        chk("clear_plot_cycles", count_sel(0, 1, 12600), 12544);
        chk("clear_busy_cycles", count_sel(1, 1, 12544), 12544);
        chk("clear_last_x",      log_x[12544], 135);
        chk("clear_last_y",      log_y[12544], 115);
        chk("clear_cell1_x",     log_x[197], 38);
        chk("clear_done_after",  log_done[12545], 1);
        chk("clear_done_count",  count_sel(2, 1, 12600), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
